mdl_pg_mc: RTL

Multi-channel, time-multiplexed pitch and phase generator. It serves CH operator slots in round-robin order, one slot per phi1 clock-enable. For each slot it applies LFO vibrato (scaled by PMS), clamps the result, and applies DT2 detune. It then converts the pitch to a phase increment and updates a per-slot phase accumulator. It sits between the register file / LFO and the operator (sine/envelope) stage.

---
 rtl/mdl_pg_mc.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mdl_pg_mc.sv
// Time-multiplexed pitch/phase generator: LFO vibrato, DT2 detune,
// pitch-to-increment conversion and a per-slot phase accumulator.
// Five enable-stage pipeline; one slot is served per phi1 enable.
module mdl_pg_mc #(
    parameter int unsigned CH        = 32,
    parameter int unsigned PHASE_W   = 20,
    parameter logic [12:0] PITCH_MAX = 13'h1FBF
) (
    input  logic                  i_EMUCLK,
    input  logic                  i_MRST_n,
    input  logic                  i_phi1_NCEN_n,
    output logic [$clog2(CH)-1:0] o_SLOT_REQ,
    input  logic [6:0]            i_KC,
    input  logic [5:0]            i_KF,
    input  logic [2:0]            i_PMS,
    input  logic [1:0]            i_DT2,
    input  logic [7:0]            i_LFP,
    input  logic                  i_PHASE_RST,
    output logic                  o_VALID,
    output logic [$clog2(CH)-1:0] o_SLOT,
    output logic [12:0]           o_PITCH,
    output logic [17:0]           o_INC,
    output logic [PHASE_W-1:0]    o_PHASE
);

    localparam int unsigned SLOT_W  = $clog2(CH);
    localparam int unsigned PITCH_W = 13;
    localparam int unsigned DEV_W   = 12;
    localparam int unsigned INC_W   = 18;

    // A slot must not come back before its previous accumulator write lands
    if (CH < 8 || CH > 64) begin : g_ch_range
        $error("mdl_pg_mc: CH must be in 8..64");
    end
    if (PHASE_W < 18 || PHASE_W > 24) begin : g_phase_range
        $error("mdl_pg_mc: PHASE_W must be in 18..24");
    end

    logic w_en;
    assign w_en = ~i_phi1_NCEN_n;

    // ------------------------------------------------------------------
    // Slot counter
    // ------------------------------------------------------------------
    logic [SLOT_W-1:0] r_slot_req;

    // Round-robin request counter, wraps CH-1 -> 0
    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            r_slot_req <= '0;
        end else if (w_en) begin
            if (r_slot_req == SLOT_W'(CH - 1)) begin
                r_slot_req <= '0;
            end else begin
                r_slot_req <= r_slot_req + SLOT_W'(1);
            end
        end
    end

    assign o_SLOT_REQ = r_slot_req;

    // ------------------------------------------------------------------
    // S1: sample inputs and compute LFO deviance
    // ------------------------------------------------------------------
    logic [13:0]        w_dev_shift;
    logic [DEV_W-1:0]   w_dev;
    logic               w_dev_neg;

    // Deviance = (mag << (PMS-1)) >> 2, zero when PMS is 0
    always_comb begin
        w_dev_shift = '0;
        if (i_PMS != 3'd0) begin
            w_dev_shift = 14'(i_LFP[6:0]) << (i_PMS - 3'd1);
        end
        w_dev     = DEV_W'(w_dev_shift >> 2);
        w_dev_neg = i_LFP[7] & (i_PMS != 3'd0);
    end

    logic                 r_s1_vld;
    logic [SLOT_W-1:0]    r_s1_slot;
    logic [PITCH_W-1:0]   r_s1_kcf;
    logic [DEV_W-1:0]     r_s1_dev;
    logic                 r_s1_neg;
    logic [1:0]           r_s1_dt2;
    logic                 r_s1_prst;

    // Stage-1 register: tag sampled inputs with the requested slot
    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            r_s1_vld  <= 1'b0;
            r_s1_slot <= '0;
            r_s1_kcf  <= '0;
            r_s1_dev  <= '0;
            r_s1_neg  <= 1'b0;
            r_s1_dt2  <= '0;
            r_s1_prst <= 1'b0;
        end else if (w_en) begin
            r_s1_vld  <= 1'b1;
            r_s1_slot <= r_slot_req;
            r_s1_kcf  <= {i_KC, i_KF};
            r_s1_dev  <= w_dev;
            r_s1_neg  <= w_dev_neg;
            r_s1_dt2  <= i_DT2;
            r_s1_prst <= i_PHASE_RST;
        end
    end

    // ------------------------------------------------------------------
    // S2: apply vibrato and clamp to [0, PITCH_MAX]
    // ------------------------------------------------------------------
    logic signed [14:0]   w_s2_sum;
    logic [PITCH_W-1:0]   w_s2_pitch;

    // One spare bit so maximum pitch plus maximum deviance cannot wrap
    always_comb begin
        if (r_s1_neg) begin
            w_s2_sum = $signed({2'b00, r_s1_kcf}) - $signed({3'b000, r_s1_dev});
        end else begin
            w_s2_sum = $signed({2'b00, r_s1_kcf}) + $signed({3'b000, r_s1_dev});
        end
        if (w_s2_sum < 15'sd0) begin
            w_s2_pitch = '0;
        end else if (w_s2_sum > $signed({2'b00, PITCH_MAX})) begin
            w_s2_pitch = PITCH_MAX;
        end else begin
            w_s2_pitch = w_s2_sum[PITCH_W-1:0];
        end
    end

    logic                 r_s2_vld;
    logic [SLOT_W-1:0]    r_s2_slot;
    logic [PITCH_W-1:0]   r_s2_pitch;
    logic [1:0]           r_s2_dt2;
    logic                 r_s2_prst;

    // Stage-2 register
    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            r_s2_vld   <= 1'b0;
            r_s2_slot  <= '0;
            r_s2_pitch <= '0;
            r_s2_dt2   <= '0;
            r_s2_prst  <= 1'b0;
        end else if (w_en) begin
            r_s2_vld   <= r_s1_vld;
            r_s2_slot  <= r_s1_slot;
            r_s2_pitch <= w_s2_pitch;
            r_s2_dt2   <= r_s1_dt2;
            r_s2_prst  <= r_s1_prst;
        end
    end

    // ------------------------------------------------------------------
    // S3: DT2 detune and upper clamp
    // ------------------------------------------------------------------
    logic [9:0]           w_dt2_add;
    logic [13:0]          w_s3_sum;
    logic [PITCH_W-1:0]   w_s3_pitch;

    // DT2 offset table followed by clamp to PITCH_MAX
    always_comb begin
        w_dt2_add = 10'd0;
        case (r_s2_dt2)
            2'd1:    w_dt2_add = 10'd384;
            2'd2:    w_dt2_add = 10'd500;
            2'd3:    w_dt2_add = 10'd608;
            default: w_dt2_add = 10'd0;
        endcase
        w_s3_sum = {1'b0, r_s2_pitch} + 14'(w_dt2_add);
        if (w_s3_sum > {1'b0, PITCH_MAX}) begin
            w_s3_pitch = PITCH_MAX;
        end else begin
            w_s3_pitch = w_s3_sum[PITCH_W-1:0];
        end
    end

    logic                 r_s3_vld;
    logic [SLOT_W-1:0]    r_s3_slot;
    logic [PITCH_W-1:0]   r_s3_pitch;
    logic                 r_s3_prst;

    // Stage-3 register
    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            r_s3_vld   <= 1'b0;
            r_s3_slot  <= '0;
            r_s3_pitch <= '0;
            r_s3_prst  <= 1'b0;
        end else if (w_en) begin
            r_s3_vld   <= r_s2_vld;
            r_s3_slot  <= r_s2_slot;
            r_s3_pitch <= w_s3_pitch;
            r_s3_prst  <= r_s2_prst;
        end
    end

    // ------------------------------------------------------------------
    // S4: pitch to phase increment
    // ------------------------------------------------------------------
    logic [INC_W-1:0] w_inc;

    // Octave shifts the implicit-one mantissa; oct <= 7 keeps it within 18 bits
    always_comb begin
        w_inc = INC_W'({1'b1, r_s3_pitch[9:0]}) << r_s3_pitch[12:10];
    end

    logic                 r_s4_vld;
    logic [SLOT_W-1:0]    r_s4_slot;
    logic [PITCH_W-1:0]   r_s4_pitch;
    logic [INC_W-1:0]     r_s4_inc;
    logic                 r_s4_prst;

    // Stage-4 register
    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            r_s4_vld   <= 1'b0;
            r_s4_slot  <= '0;
            r_s4_pitch <= '0;
            r_s4_inc   <= '0;
            r_s4_prst  <= 1'b0;
        end else if (w_en) begin
            r_s4_vld   <= r_s3_vld;
            r_s4_slot  <= r_s3_slot;
            r_s4_pitch <= r_s3_pitch;
            r_s4_inc   <= w_inc;
            r_s4_prst  <= r_s3_prst;
        end
    end

    // ------------------------------------------------------------------
    // S5: phase accumulator and output register
    // ------------------------------------------------------------------
    logic [PHASE_W-1:0] r_acc [CH];
    logic [PHASE_W-1:0] w_acc_rd;
    logic [PHASE_W-1:0] w_acc_nx;

    // Next phase for the slot leaving S4; key-on forces zero
    always_comb begin
        w_acc_rd = r_acc[r_s4_slot];
        if (r_s4_prst) begin
            w_acc_nx = '0;
        end else begin
            w_acc_nx = w_acc_rd + PHASE_W'(r_s4_inc);
        end
    end

    // Accumulator array; reset clears every slot in one edge
    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            for (int i = 0; i < int'(CH); i++) begin
                r_acc[i] <= '0;
            end
        end else if (w_en && r_s4_vld) begin
            r_acc[r_s4_slot] <= w_acc_nx;
        end
    end

    logic                 r_valid;
    logic [SLOT_W-1:0]    r_slot;
    logic [PITCH_W-1:0]   r_pitch;
    logic [INC_W-1:0]     r_inc;
    logic [PHASE_W-1:0]   r_phase;

    // Output register; holds the last result between enables
    always_ff @(posedge i_EMUCLK) begin
        if (!i_MRST_n) begin
            r_valid <= 1'b0;
            r_slot  <= '0;
            r_pitch <= '0;
            r_inc   <= '0;
            r_phase <= '0;
        end else if (w_en && r_s4_vld) begin
            r_valid <= 1'b1;
            r_slot  <= r_s4_slot;
            r_pitch <= r_s4_pitch;
            r_inc   <= r_s4_inc;
            r_phase <= w_acc_nx;
        end
    end

    assign o_VALID = r_valid;
    assign o_SLOT  = r_slot;
    assign o_PITCH = r_pitch;
    assign o_INC   = r_inc;
    assign o_PHASE = r_phase;

endmodule
